mac_serial2d_seq: RTL and testbench

Control sequencer for the 2D bit-serial MAC datapath. For each accepted operand pair it generates the per-cycle control stream: `w_sel`, `a_sel`, `sign_ctr`, `shift_ctr`, `rst_mult` and `slow_tick`. The stream walks every partial product `a[i]·w[j]` in column order, least-significant column first. The block sits directly upstream of the MAC input registers and runs on the same fast clock.

---
 rtl/mac_serial2d_pkg.sv | 30 +++
 rtl/mac_serial2d_colgen.sv | 20 ++
 rtl/mac_serial2d_seq.sv | 151 +++++++++++++++
 tb/tb_mac_serial2d_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mac_serial2d_pkg.sv
// Shared types and precision decode for the 2D bit-serial MAC sequencer.
package mac_serial2d_pkg;

    localparam logic [3:0] MODE_8X8 = 4'b0000;
    localparam logic [3:0] MODE_4X4 = 4'b0111;
    localparam logic [3:0] MODE_2X2 = 4'b1111;
    localparam logic [3:0] MODE_8X4 = 4'b0001;
    localparam logic [3:0] MODE_8X2 = 4'b0011;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

    typedef struct packed {
        logic [3:0] wa;
        logic [3:0] ww;
    } prec_t;

    // Unknown encodings fall back to full 8x8 precision.
    function automatic prec_t prec_decode(input logic [3:0] mode);
        prec_t p;
        case (mode)
            MODE_4X4: p = '{wa: 4'd4, ww: 4'd4};
            MODE_2X2: p = '{wa: 4'd2, ww: 4'd2};
            MODE_8X4: p = '{wa: 4'd8, ww: 4'd4};
            MODE_8X2: p = '{wa: 4'd8, ww: 4'd2};
            default:  p = '{wa: 4'd8, ww: 4'd8};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mac_serial2d_colgen.sv
// Column bounds for partial-product column k: j runs from j_lo to j_hi.
module mac_serial2d_colgen
    import mac_serial2d_pkg::*;
(
    input  logic [3:0] k,
    input  logic [3:0] wa,
    input  logic [3:0] ww,
    output logic [2:0] j_lo,
    output logic [2:0] j_hi
);

    logic [3:0] ww_m1;

    always_comb begin
        ww_m1 = ww - 4'd1;
        j_lo  = (k >= wa) ? 3'(k - wa + 4'd1) : 3'd0;
        j_hi  = (k < ww_m1) ? k[2:0] : ww_m1[2:0];
    end

endmodule

// File: rtl/mac_serial2d_seq.sv
// Control sequencer walking a[i]*w[j] partial products column by column,
// with back-to-back accepts folding the drain into the next multiply.
module mac_serial2d_seq
    import mac_serial2d_pkg::*;
#(
    parameter int unsigned AW_MAX = 8,
    parameter int unsigned WW_MAX = 8
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic [3:0] mode,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] w_sel,
    output logic [2:0] a_sel,
    output logic       sign_ctr,
    output logic       shift_ctr,
    output logic       rst_mult,
    output logic       slow_tick,
    output logic       busy,
    output logic       done
);

    seq_state_t state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [2:0] j_q, j_d;
    logic [3:0] wa_q, wa_d, ww_q, ww_d;
    logic [2:0] j_hi_q, j_hi_d, j_lo_d;
    logic [2:0] w_sel_q, w_sel_d, a_sel_q, a_sel_d;
    logic       sign_q, sign_d, shift_q, shift_d;
    logic       rst_mult_q, rst_mult_d, busy_q, busy_d, done_q, done_d;
    logic [3:0] last_k_q, last_k_d;
    logic       last_prod, accept, adv_col, j_inc;
    prec_t      dec;

    assign last_k_q  = wa_q + ww_q - 4'd2;
    assign last_prod = (state_q == RUN) && (k_q == last_k_q) && (j_q == j_hi_q);
    assign in_ready  = !rst && ((state_q == IDLE) || last_prod);
    assign accept    = in_valid && in_ready;

    // Bounds are evaluated for the column we are about to enter.
    mac_serial2d_colgen u_colgen (
        .k    (k_d),
        .wa   (wa_d),
        .ww   (ww_d),
        .j_lo (j_lo_d),
        .j_hi (j_hi_d)
    );

    always_comb begin
        dec     = prec_decode(mode);
        state_d = state_q;
        k_d     = k_q;
        wa_d    = wa_q;
        ww_d    = ww_q;
        adv_col = 1'b0;
        j_inc   = 1'b0;
        if (accept) begin
            state_d = RUN;
            k_d     = 4'd0;
            wa_d    = (dec.wa > 4'(AW_MAX)) ? 4'(AW_MAX) : dec.wa;
            ww_d    = (dec.ww > 4'(WW_MAX)) ? 4'(WW_MAX) : dec.ww;
        end else begin
            case (state_q)
                RUN: begin
                    if (last_prod) begin
                        state_d = DRAIN;
                        k_d     = 4'd0;
                    end else if (j_q == j_hi_q) begin
                        k_d     = k_q + 4'd1;
                        adv_col = 1'b1;
                    end else begin
                        j_inc = 1'b1;
                    end
                end
                DRAIN:   state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are precomputed from the next state so they register in step with it.
    always_comb begin
        j_d = 3'd0;
        if (j_inc) begin
            j_d = j_q + 3'd1;
        end else if (adv_col) begin
            j_d = j_lo_d;
        end
        last_k_d   = wa_d + ww_d - 4'd2;
        w_sel_d    = 3'd0;
        a_sel_d    = 3'd0;
        sign_d     = 1'b0;
        shift_d    = 1'b0;
        rst_mult_d = 1'b0;
        done_d     = 1'b0;
        if (state_d == RUN) begin
            w_sel_d    = j_d;
            a_sel_d    = 3'(k_d - {1'b0, j_d});
            sign_d     = ({1'b0, j_d} == (ww_d - 4'd1));
            shift_d    = (j_d == j_hi_d);
            rst_mult_d = (k_d == 4'd0);
            done_d     = (k_d == last_k_d) && (j_d == j_hi_d);
        end else if (state_d == DRAIN) begin
            rst_mult_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= 4'd0;
            j_q        <= 3'd0;
            wa_q       <= 4'd8;
            ww_q       <= 4'd8;
            j_hi_q     <= 3'd0;
            w_sel_q    <= 3'd0;
            a_sel_q    <= 3'd0;
            sign_q     <= 1'b0;
            shift_q    <= 1'b0;
            rst_mult_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            j_q        <= j_d;
            wa_q       <= wa_d;
            ww_q       <= ww_d;
            j_hi_q     <= j_hi_d;
            w_sel_q    <= w_sel_d;
            a_sel_q    <= a_sel_d;
            sign_q     <= sign_d;
            shift_q    <= shift_d;
            rst_mult_q <= rst_mult_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign w_sel     = w_sel_q;
    assign a_sel     = a_sel_q;
    assign sign_ctr  = sign_q;
    assign shift_ctr = shift_q;
    assign rst_mult  = rst_mult_q;
    assign slow_tick = rst_mult_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mac_serial2d_seq.sv
// Directed bench for mac_serial2d_seq: hand-computed 2x2 trace plus a
// column-order model for the longer multiplies.
module tb_mac_serial2d_seq;

    logic       clk_fast = 1'b0;
    logic       rst;
    logic [3:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] w_sel, a_sel;
    logic       sign_ctr, shift_ctr, rst_mult, slow_tick, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [12:0] PAT_RESET = 13'b0000000_000_000;
    localparam logic [12:0] PAT_IDLE  = 13'b0000001_000_000;
    localparam logic [12:0] PAT_DRAIN = 13'b1100010_000_000;

    mac_serial2d_seq #(.AW_MAX(8), .WW_MAX(8)) dut (
        .clk_fast  (clk_fast),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_sel     (w_sel),
        .a_sel     (a_sel),
        .sign_ctr  (sign_ctr),
        .shift_ctr (shift_ctr),
        .rst_mult  (rst_mult),
        .slow_tick (slow_tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_fast = ~clk_fast;

    // {rst_mult, slow_tick, sign, shift, done, busy, in_ready, a_sel, w_sel}
    function automatic logic [12:0] pack_out();
        return {rst_mult, slow_tick, sign_ctr, shift_ctr, done, busy, in_ready, a_sel, w_sel};
    endfunction

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [3:0] m);
        in_valid = valid;
        mode     = m;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on the first product cycle; returns on the last product cycle.
    task automatic expect_mult(input int wa, input int ww, input string tag);
        int         errs, shifts, signs, last_k, lo, hi;
        logic [63:0] seen;
        bit         is_last;
        errs   = 0;
        shifts = 0;
        signs  = 0;
        seen   = '0;
        last_k = wa + ww - 2;
        for (int k = 0; k <= last_k; k++) begin
            lo = (k >= wa) ? k - wa + 1 : 0;
            hi = (k < ww - 1) ? k : ww - 1;
            for (int j = lo; j <= hi; j++) begin
                is_last = (k == last_k) && (j == hi);
                if (a_sel !== 3'(k - j) || w_sel !== 3'(j) ||
                    sign_ctr !== (j == ww - 1) || shift_ctr !== (j == hi) ||
                    rst_mult !== (k == 0) || slow_tick !== (k == 0) ||
                    done !== is_last || busy !== 1'b1 || in_ready !== is_last) begin
                    errs++;
                end
                shifts += int'(shift_ctr);
                signs  += int'(sign_ctr);
                seen[{a_sel, w_sel}] = 1'b1;
                if (!is_last) tick();
            end
        end
        check_output({tag, " order"}, errs, 0);
        check_output({tag, " shift pulses"}, shifts, wa + ww - 1);
        check_output({tag, " sign pulses"}, signs, wa);
        check_output({tag, " pairs"}, $countones(seen), wa * ww);
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 4'b0000);
        tick();
        tick();
        check_output("reset outputs", pack_out(), PAT_RESET);
        rst = 1'b0;
        tick();
        check_output("idle after reset", pack_out(), PAT_IDLE);

        // 2x2 hand trace
        apply_stimulus(1'b1, 4'b1111);
        tick();
        apply_stimulus(1'b0, 4'b1111);
        check_output("2x2 t1", pack_out(), 13'b1101010_000_000);
        tick();
        check_output("2x2 t2", pack_out(), 13'b0000010_001_000);
        tick();
        check_output("2x2 t3", pack_out(), 13'b0011010_000_001);
        tick();
        check_output("2x2 t4", pack_out(), 13'b0011111_001_001);
        tick();
        check_output("2x2 drain", pack_out(), PAT_DRAIN);
        tick();
        check_output("2x2 idle", pack_out(), PAT_IDLE);

        // 8x8 single multiply
        apply_stimulus(1'b1, 4'b0000);
        tick();
        apply_stimulus(1'b0, 4'b0000);
        expect_mult(8, 8, "8x8");
        tick();
        check_output("8x8 drain", pack_out(), PAT_DRAIN);
        tick();
        check_output("8x8 idle", pack_out(), PAT_IDLE);

        // 8x4 back-to-back with in_valid held high
        apply_stimulus(1'b1, 4'b0001);
        tick();
        expect_mult(8, 4, "8x4 first");
        tick();
        expect_mult(8, 4, "8x4 second");
        apply_stimulus(1'b0, 4'b0001);
        tick();
        check_output("8x4 drain", pack_out(), PAT_DRAIN);
        tick();
        check_output("8x4 idle", pack_out(), PAT_IDLE);

        // mode flipped mid-multiply only affects the next accept
        apply_stimulus(1'b1, 4'b0000);
        tick();
        apply_stimulus(1'b1, 4'b1111);
        expect_mult(8, 8, "flip 8x8");
        tick();
        expect_mult(2, 2, "flip next 2x2");
        apply_stimulus(1'b0, 4'b1111);
        tick();
        check_output("flip drain", pack_out(), PAT_DRAIN);
        tick();
        check_output("flip idle", pack_out(), PAT_IDLE);

        // reset on the 10th RUN cycle
        apply_stimulus(1'b1, 4'b0000);
        tick();
        apply_stimulus(1'b0, 4'b0000);
        repeat (9) tick();
        check_output("run10 busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check_output("abort outputs", pack_out(), PAT_RESET);
        rst = 1'b0;
        tick();
        check_output("abort idle", pack_out(), PAT_IDLE);

        // illegal encoding runs as 8x8
        apply_stimulus(1'b1, 4'b0101);
        tick();
        apply_stimulus(1'b0, 4'b0101);
        expect_mult(8, 8, "illegal");
        tick();
        check_output("illegal drain", pack_out(), PAT_DRAIN);
        tick();
        check_output("illegal idle", pack_out(), PAT_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
